// File: rtl/parallel_out_arbiter_pkg.sv
// par_out_pkg: shared FSM states, default output addresses and requester ids for the parallel output arbiter
package par_out_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, REJECT, ACK} state_t;
  localparam logic [31:0] DEF_ADDR_OUT0 = 32'h0FF;
  localparam logic [31:0] DEF_ADDR_OUT1 = 32'h0FE;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/parallel_out_arbiter_if.sv
// parallel_out_arbiter_if: two requester handshakes plus output bank bus (shadow readback when PAR_OUT_SHADOW_EN)
interface parallel_out_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ack;
  logic              req0_err;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ack;
  logic              req1_err;
  logic              out_en;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
`ifdef PAR_OUT_SHADOW_EN
  logic [DATA_W-1:0] shadow0;
  logic [DATA_W-1:0] shadow1;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ack, req0_err, req1_ack, req1_err, out_en, out_addr, out_data, busy, shadow0, shadow1
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ack, req0_err, req1_ack, req1_err, out_en, out_addr, out_data, busy, shadow0, shadow1
  );
`else
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ack, req0_err, req1_ack, req1_err, out_en, out_addr, out_data, busy
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ack, req0_err, req1_ack, req1_err, out_en, out_addr, out_data, busy
  );
`endif
endinterface

// File: rtl/parallel_out_arbiter_rr2.sv
// par_out_rr2: combinational 2-way round-robin picker; the last_grant state is held by the parent
module par_out_rr2
  import par_out_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_any
);
  // contention goes to the requester that did not win the last contended round
  always_comb begin
    grant_any = |valid;
    grant_id  = &valid ? ~last_grant : (valid[1] ? REQ_DBG : REQ_CPU);
  end
endmodule

// File: rtl/parallel_out_arbiter.sv
// parallel_out_arbiter: round-robin write arbiter for the parallel output bank; PAR_OUT_SHADOW_EN adds shadow readback registers
module parallel_out_arbiter
  import par_out_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_OUT0 = ADDR_W'(DEF_ADDR_OUT0),
  parameter logic [ADDR_W-1:0] ADDR_OUT1 = ADDR_W'(DEF_ADDR_OUT1)
) (
  input logic clk,
  input logic rst,
  parallel_out_arbiter_if.slave bus
);
  state_t            state, state_nx;
  logic              win, legal, last_grant, grant_id, grant_any, sel_legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  par_out_rr2 u_rr (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant_id   (grant_id),
    .grant_any  (grant_any)
  );
  // winner's payload and exact-match address decode
  always_comb begin
    sel_addr  = grant_id ? bus.req1_addr : bus.req0_addr;
    sel_data  = grant_id ? bus.req1_data : bus.req0_data;
    sel_legal = (sel_addr == ADDR_OUT0) || (sel_addr == ADDR_OUT1);
  end
  // state register; async reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // IDLE -> WRITE|REJECT -> ACK -> IDLE, one cycle per state
  always_comb
    state_nx = (state == IDLE) ? (grant_any ? (sel_legal ? WRITE : REJECT) : IDLE)
             : (state == ACK) ? IDLE : ACK;
  // strobe, ack and busy decode straight from the state
  always_comb begin
    bus.out_en   = state == WRITE;
    bus.busy     = state != IDLE;
    bus.req0_ack = (state == ACK) && (win == REQ_CPU);
    bus.req1_ack = (state == ACK) && (win == REQ_DBG);
    bus.req0_err = bus.req0_ack && !legal;
    bus.req1_err = bus.req1_ack && !legal;
  end
  // latch the winner in IDLE; only contended rounds move the round-robin pointer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.out_addr <= '0;
      bus.out_data <= '0;
      win          <= REQ_CPU;
      legal        <= 1'b0;
      last_grant   <= REQ_DBG;
    end else if (state == IDLE && grant_any) begin
      bus.out_addr <= sel_addr;
      bus.out_data <= sel_data;
      win          <= grant_id;
      legal        <= sel_legal;
      if (&{bus.req1_valid, bus.req0_valid}) last_grant <= grant_id;
    end
`ifdef PAR_OUT_SHADOW_EN
  // mirror each strobed write into the shadow of its target register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.shadow0 <= '0;
      bus.shadow1 <= '0;
    end else if (state == WRITE) begin
      bus.shadow0 <= (bus.out_addr == ADDR_OUT0) ? bus.out_data : bus.shadow0;
      bus.shadow1 <= (bus.out_addr == ADDR_OUT1) ? bus.out_data : bus.shadow1;
    end
`endif
endmodule
